// File: rtl/pipelined_riscv_uc.sv
// Pipelined control unit for the five-stage RISC-V core: decodes in Decode and carries
// the control word through D/E, E/M and M/W. Optional bne support under macro UC_BNE_EN.
module pipelined_riscv_uc (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zeroE,
    input  logic       FlushE,
    output logic [1:0] ImmSrcD,
    output logic       ALUSrcE,
    output logic [2:0] ALUControlE,
    output logic       PCSrcE,
    output logic       ResultSrcE0,
    output logic       RegWriteM,
    output logic       MemWriteM,
    output logic       RegWriteW,
    output logic [1:0] ResultSrcW
);

    // Decode-stage control word
    logic       reg_write_d_s;
    logic [1:0] result_src_d_s;
    logic       mem_write_d_s;
    logic       jump_d_s;
    logic       branch_d_s;
    logic       alu_src_d_s;
    logic [1:0] alu_op_d_s;
    logic [1:0] imm_src_d_s;
    logic [2:0] alu_control_d_s;

    // D/E stage
    logic       reg_write_e_r;
    logic [1:0] result_src_e_r;
    logic       mem_write_e_r;
    logic       jump_e_r;
    logic       branch_e_r;
    logic       alu_src_e_r;
    logic [2:0] alu_control_e_r;

    // E/M and M/W stages
    logic       reg_write_m_r;
    logic [1:0] result_src_m_r;
    logic       mem_write_m_r;
    logic       reg_write_w_r;
    logic [1:0] result_src_w_r;

    // Main decoder: opcode to control word and immediate format
    always_comb begin
        reg_write_d_s  = 1'b0;
        result_src_d_s = 2'b00;
        mem_write_d_s  = 1'b0;
        jump_d_s       = 1'b0;
        branch_d_s     = 1'b0;
        alu_src_d_s    = 1'b0;
        alu_op_d_s     = 2'b00;
        imm_src_d_s    = 2'b00;
        case (opcode)
            7'b0000011: begin
                reg_write_d_s  = 1'b1;
                result_src_d_s = 2'b01;
                alu_src_d_s    = 1'b1;
            end
            7'b0100011: begin
                mem_write_d_s = 1'b1;
                alu_src_d_s   = 1'b1;
                imm_src_d_s   = 2'b01;
            end
            7'b0110011: begin
                reg_write_d_s = 1'b1;
                alu_op_d_s    = 2'b10;
            end
            7'b0010011: begin
                reg_write_d_s = 1'b1;
                alu_src_d_s   = 1'b1;
                alu_op_d_s    = 2'b10;
            end
            7'b1100011: begin
                branch_d_s  = 1'b1;
                alu_op_d_s  = 2'b01;
                imm_src_d_s = 2'b10;
            end
            7'b1101111: begin
                reg_write_d_s  = 1'b1;
                result_src_d_s = 2'b10;
                jump_d_s       = 1'b1;
                imm_src_d_s    = 2'b11;
            end
            default: begin
                reg_write_d_s = 1'b0;
            end
        endcase
    end

    // ALU decoder: subtraction only for R-type with func7[5], never for addi
    always_comb begin
        alu_control_d_s = 3'b000;
        case (alu_op_d_s)
            2'b00: alu_control_d_s = 3'b000;
            2'b01: alu_control_d_s = 3'b001;
            2'b10: begin
                case (func3)
                    3'b000: begin
                        if (opcode[5] & func7[5]) begin
                            alu_control_d_s = 3'b001;
                        end else begin
                            alu_control_d_s = 3'b000;
                        end
                    end
                    3'b010:  alu_control_d_s = 3'b101;
                    3'b110:  alu_control_d_s = 3'b011;
                    3'b111:  alu_control_d_s = 3'b010;
                    default: alu_control_d_s = 3'b000;
                endcase
            end
            default: alu_control_d_s = 3'b000;
        endcase
    end

    // D/E control register; FlushE inserts a bubble
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_write_e_r   <= 1'b0;
            result_src_e_r  <= 2'b00;
            mem_write_e_r   <= 1'b0;
            jump_e_r        <= 1'b0;
            branch_e_r      <= 1'b0;
            alu_src_e_r     <= 1'b0;
            alu_control_e_r <= 3'b000;
        end else if (FlushE) begin
            reg_write_e_r   <= 1'b0;
            result_src_e_r  <= 2'b00;
            mem_write_e_r   <= 1'b0;
            jump_e_r        <= 1'b0;
            branch_e_r      <= 1'b0;
            alu_src_e_r     <= 1'b0;
            alu_control_e_r <= 3'b000;
        end else begin
            reg_write_e_r   <= reg_write_d_s;
            result_src_e_r  <= result_src_d_s;
            mem_write_e_r   <= mem_write_d_s;
            jump_e_r        <= jump_d_s;
            branch_e_r      <= branch_d_s;
            alu_src_e_r     <= alu_src_d_s;
            alu_control_e_r <= alu_control_d_s;
        end
    end

`ifdef UC_BNE_EN
    logic branch_neg_e_r;

    // func3[0] distinguishes bne from beq in Execute
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            branch_neg_e_r <= 1'b0;
        end else if (FlushE) begin
            branch_neg_e_r <= 1'b0;
        end else begin
            branch_neg_e_r <= func3[0];
        end
    end

    assign PCSrcE = (branch_e_r & (zeroE ^ branch_neg_e_r)) | jump_e_r;
`else
    assign PCSrcE = (branch_e_r & zeroE) | jump_e_r;
`endif

    // E/M and M/W control registers always advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            reg_write_m_r  <= 1'b0;
            result_src_m_r <= 2'b00;
            mem_write_m_r  <= 1'b0;
            reg_write_w_r  <= 1'b0;
            result_src_w_r <= 2'b00;
        end else begin
            reg_write_m_r  <= reg_write_e_r;
            result_src_m_r <= result_src_e_r;
            mem_write_m_r  <= mem_write_e_r;
            reg_write_w_r  <= reg_write_m_r;
            result_src_w_r <= result_src_m_r;
        end
    end

    assign ImmSrcD     = imm_src_d_s;
    assign ALUSrcE     = alu_src_e_r;
    assign ALUControlE = alu_control_e_r;
    assign ResultSrcE0 = result_src_e_r[0];
    assign RegWriteM   = reg_write_m_r;
    assign MemWriteM   = mem_write_m_r;
    assign RegWriteW   = reg_write_w_r;
    assign ResultSrcW  = result_src_w_r;

endmodule

// File: tb/tb_pipelined_riscv_uc.sv
// Directed self-checking bench for pipelined_riscv_uc; expectations follow the
// UC_BNE_EN setting the bench is compiled with.
module tb_pipelined_riscv_uc;

    logic       clock;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zeroE;
    logic       FlushE;
    logic [1:0] ImmSrcD;
    logic       ALUSrcE;
    logic [2:0] ALUControlE;
    logic       PCSrcE;
    logic       ResultSrcE0;
    logic       RegWriteM;
    logic       MemWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

`ifdef UC_BNE_EN
    localparam logic BNE_ON = 1'b1;
`else
    localparam logic BNE_ON = 1'b0;
`endif

    pipelined_riscv_uc dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .zeroE       (zeroE),
        .FlushE      (FlushE),
        .ImmSrcD     (ImmSrcD),
        .ALUSrcE     (ALUSrcE),
        .ALUControlE (ALUControlE),
        .PCSrcE      (PCSrcE),
        .ResultSrcE0 (ResultSrcE0),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcW  (ResultSrcW)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        func3  = f3;
        func7  = f7;
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        zeroE  = 1'b0;
        FlushE = 1'b0;
        drive(OP_R, 3'b000, 7'b0000000);

        // Reset held for three cycles with an R-type in Decode
        tick(); tick(); tick();
        check("rst_alusrc",    {3'b0, ALUSrcE},     4'h0);
        check("rst_aluctl",    {1'b0, ALUControlE}, 4'h0);
        check("rst_pcsrc",     {3'b0, PCSrcE},      4'h0);
        check("rst_ressrce0",  {3'b0, ResultSrcE0}, 4'h0);
        check("rst_regwritem", {3'b0, RegWriteM},   4'h0);
        check("rst_memwritem", {3'b0, MemWriteM},   4'h0);
        check("rst_regwritew", {3'b0, RegWriteW},   4'h0);
        check("rst_ressrcw",   {2'b0, ResultSrcW},  4'h0);
        check("rst_immsrc",    {2'b0, ImmSrcD},     4'h0);

        reset = 1'b1;
        tick();
        check("rel_alusrc",    {3'b0, ALUSrcE},     4'h0);
        check("rel_aluctl",    {1'b0, ALUControlE}, 4'h0);
        check("rel_regwritem", {3'b0, RegWriteM},   4'h0);

        // Load flow
        drive(OP_LOAD, 3'b010, 7'b0000000);
        check("ld_immsrc", {2'b0, ImmSrcD}, 4'h0);
        tick();
        check("ld_alusrc",   {3'b0, ALUSrcE},     4'h1);
        check("ld_ressrce0", {3'b0, ResultSrcE0}, 4'h1);
        check("ld_aluctl",   {1'b0, ALUControlE}, 4'h0);
        drive(OP_NOP, 3'b000, 7'b0000000);
        tick();
        check("ld_regwritem", {3'b0, RegWriteM},   4'h1);
        check("ld_memwritem", {3'b0, MemWriteM},   4'h0);
        check("nop_ressrce0", {3'b0, ResultSrcE0}, 4'h0);
        tick();
        check("ld_regwritew", {3'b0, RegWriteW},  4'h1);
        check("ld_ressrcw",   {2'b0, ResultSrcW}, 4'h1);
        tick();
        check("nop_regwritew", {3'b0, RegWriteW}, 4'h0);

        // R-type and I-type ALU decoding
        drive(OP_R, 3'b000, 7'b0100000);
        tick();
        check("r_sub",        {1'b0, ALUControlE}, 4'h1);
        check("r_sub_alusrc", {3'b0, ALUSrcE},     4'h0);
        drive(OP_R, 3'b111, 7'b0000000);
        tick();
        check("r_and", {1'b0, ALUControlE}, 4'h2);
        drive(OP_R, 3'b010, 7'b0000000);
        tick();
        check("r_slt", {1'b0, ALUControlE}, 4'h5);
        drive(OP_R, 3'b110, 7'b0000000);
        tick();
        check("r_or", {1'b0, ALUControlE}, 4'h3);
        drive(OP_R, 3'b001, 7'b0000000);
        tick();
        check("r_other_add", {1'b0, ALUControlE}, 4'h0);
        drive(OP_I, 3'b000, 7'b0100000);
        check("addi_immsrc", {2'b0, ImmSrcD}, 4'h0);
        tick();
        check("addi_add",    {1'b0, ALUControlE}, 4'h0);
        check("addi_alusrc", {3'b0, ALUSrcE},     4'h1);

        // beq resolves against zeroE in the same cycle
        drive(OP_BR, 3'b000, 7'b0000000);
        check("br_immsrc", {2'b0, ImmSrcD}, 4'h2);
        tick();
        check("br_aluctl", {1'b0, ALUControlE}, 4'h1);
        zeroE = 1'b1; #1;
        check("beq_taken", {3'b0, PCSrcE}, 4'h1);
        zeroE = 1'b0; #1;
        check("beq_not_taken", {3'b0, PCSrcE}, 4'h0);

        // jal: taken regardless of zeroE, writes PC+4 two cycles later
        drive(OP_JAL, 3'b000, 7'b0000000);
        check("jal_immsrc", {2'b0, ImmSrcD}, 4'h3);
        tick();
        check("jal_pcsrc_z0", {3'b0, PCSrcE}, 4'h1);
        zeroE = 1'b1; #1;
        check("jal_pcsrc_z1", {3'b0, PCSrcE}, 4'h1);
        zeroE = 1'b0;
        drive(OP_NOP, 3'b000, 7'b0000000);
        tick();
        check("jal_regwritem", {3'b0, RegWriteM}, 4'h1);
        check("nop_pcsrc",     {3'b0, PCSrcE},    4'h0);
        tick();
        check("jal_ressrcw", {2'b0, ResultSrcW}, 4'h2);

        // func3 = 001 branch: bne when enabled, beq otherwise
        drive(OP_BR, 3'b001, 7'b0000000);
        tick();
        zeroE = 1'b0; #1;
        check("bne_z0", {3'b0, PCSrcE}, {3'b0, BNE_ON});
        zeroE = 1'b1; #1;
        check("bne_z1", {3'b0, PCSrcE}, {3'b0, ~BNE_ON});
        zeroE = 1'b0;

        // Unrecognised opcode decodes as a NOP
        drive(7'b1111111, 3'b111, 7'b1111111);
        check("bad_immsrc", {2'b0, ImmSrcD}, 4'h0);
        tick();
        check("bad_alusrc", {3'b0, ALUSrcE},     4'h0);
        check("bad_aluctl", {1'b0, ALUControlE}, 4'h0);
        check("bad_pcsrc",  {3'b0, PCSrcE},      4'h0);

        // Unflushed store reaches Memory
        drive(OP_STORE, 3'b010, 7'b0000000);
        check("sw_immsrc", {2'b0, ImmSrcD}, 4'h1);
        tick();
        drive(OP_NOP, 3'b000, 7'b0000000);
        tick();
        check("sw_memwritem", {3'b0, MemWriteM}, 4'h1);
        check("sw_regwritem", {3'b0, RegWriteM}, 4'h0);

        // Flushed store behind a load: load still retires, store does not write
        drive(OP_LOAD, 3'b010, 7'b0000000);
        tick();
        drive(OP_STORE, 3'b010, 7'b0000000);
        FlushE = 1'b1;
        tick();
        check("fl_bubble_alusrc", {3'b0, ALUSrcE},   4'h0);
        check("fl_ld_regwritem",  {3'b0, RegWriteM}, 4'h1);
        check("fl_ld_memwritem",  {3'b0, MemWriteM}, 4'h0);
        FlushE = 1'b0;
        drive(OP_NOP, 3'b000, 7'b0000000);
        tick();
        check("fl_sw_memwritem", {3'b0, MemWriteM},  4'h0);
        check("fl_ld_regwritew", {3'b0, RegWriteW},  4'h1);
        check("fl_ld_ressrcw",   {2'b0, ResultSrcW}, 4'h1);

        // Mid-operation reset clears state asynchronously
        drive(OP_JAL, 3'b000, 7'b0000000);
        tick();
        check("pre_rst_pcsrc", {3'b0, PCSrcE}, 4'h1);
        tick();
        check("pre_rst_regwritem", {3'b0, RegWriteM}, 4'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_pcsrc",     {3'b0, PCSrcE},     4'h0);
        check("async_regwritem", {3'b0, RegWriteM},  4'h0);
        check("async_regwritew", {3'b0, RegWriteW},  4'h0);
        check("async_ressrcw",   {2'b0, ResultSrcW}, 4'h0);
        tick();
        reset = 1'b1;
        drive(OP_NOP, 3'b000, 7'b0000000);
        tick();
        check("post_rst_pcsrc", {3'b0, PCSrcE}, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_riscv_uc.md
# pipelined_riscv_uc

Pipelined control unit for the five-stage RISC-V core. It decodes the instruction held in the Decode stage (opcode/func3/func7) and carries the resulting control word through its own D/E, E/M and M/W registers, kept in lockstep with the datapath pipeline registers. It delivers every control input the datapath consumes (ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, MemWriteM, RegWriteW, ResultSrcW), plus the stage-tagged signals the hazard unit needs.

## Interface
- No parameters.
- clock  input  1  pipeline clock; all registers update on its rising edge.
- reset  input  1  asynchronous, active-low (0 = reset); clears all control registers immediately.
- opcode  input  7  Decode-stage instruction bits [6:0].
- func3  input  3  Decode-stage instruction bits [14:12].
- func7  input  7  Decode-stage instruction bits [31:25].
- zeroE  input  1  ALU zero flag from Execute.
- FlushE  input  1  hazard unit; bubble into the D/E control register.
- ImmSrcD  output  2  immediate format, combinational from Decode: I=00, S=01, B=10, J=11.
- ALUSrcE  output  1  1 = immediate operand B.
- ALUControlE  output  3  add=000, sub=001, and=010, or=011, slt=101.
- PCSrcE  output  1  take branch/jump target.
- ResultSrcE0  output  1  bit 0 of ResultSrcE (load in Execute), for load-use stall detection.
- RegWriteM  output  1  Memory-stage register write, for forwarding.
- MemWriteM  output  1  data-memory write enable.
- RegWriteW  output  1  register-file write enable.
- ResultSrcW  output  2  00 = ALU, 01 = memory, 10 = PC+4.

## Operation
- Main decoder (combinational, Decode): control word {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUOp[1:0]}. ImmSrcD is taken directly from the decoder.
  - 0000011 load: 1,01,0,0,0,1,00; ImmSrc 00.
  - 0100011 store: 0,00,1,0,0,1,00; ImmSrc 01.
  - 0110011 R-type: 1,00,0,0,0,0,10.
  - 0010011 I-ALU: 1,00,0,0,0,1,10; ImmSrc 00.
  - 1100011 branch: 0,00,0,0,1,0,01; ImmSrc 10.
  - 1101111 jal: 1,10,0,1,0,0,00; ImmSrc 11.
  - Any other opcode, including 0000000 (flushed IF/ID): all zeros, ImmSrc 00. Acts as a NOP.
- ALU decoder: ALUOp 00 gives add. ALUOp 01 gives sub. ALUOp 10 decodes by func3:
  - 000: sub if opcode[5] & func7[5], else add.
  - 010: slt. 110: or. 111: and.
  - Any other func3: add.
- D/E register holds RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl, plus func3 when BNE_EN is set. E/M holds RegWrite, ResultSrc, MemWrite. M/W holds RegWrite, ResultSrc.
- PCSrcE = (BranchE & zeroE) | JumpE, combinational.
- FlushE = 1 at an edge loads zeros into D/E. The E/M and M/W registers still advance, so the bubble propagates.
- No stall input. When Decode is stalled, the hazard unit asserts FlushE, so the same instruction is not duplicated into Execute.

## Timing
- Reset (asynchronous, active-low): all registered outputs are 0 and PCSrcE = 0, as long as reset is asserted and until the first edge after release.
- Release is synchronous to the next rising edge; no pipeline state survives a mid-operation reset.
- An instruction in Decode at edge N has its control in E after N, in M after N+1, and in W after N+2.
- ImmSrcD has zero-cycle latency from opcode.
- PCSrcE depends combinationally on zeroE in the same cycle.
- FlushE dominates the D/E register; it does not affect E/M or M/W.

## Configuration
- UC_BNE_EN defined: opcode 1100011 with func3 = 001 is decoded as bne. The D/E register carries funct3 bit 0 as BranchNegE, and PCSrcE = (BranchE & (zeroE ^ BranchNegE)) | JumpE.
- UC_BNE_EN undefined: every branch is beq, and func3 is ignored for branches.

## Test plan
- Reset: hold reset = 0 for 3 cycles with opcode = 0110011. Required: all outputs 0. Release reset, and one edge later ALUSrcE = 0, ALUControlE = 000, RegWriteM = 0.
- Load flow: opcode = 0000011 held for one cycle, then NOP. Required:
  - ImmSrcD = 00 immediately.
  - After edge 1: ALUSrcE = 1, ResultSrcE0 = 1.
  - After edge 2: RegWriteM = 1.
  - After edge 3: RegWriteW = 1, ResultSrcW = 01.
- R-type sub/and/slt: opcode 0110011 with func3/func7 = 000/0100000, then 111/0000000, then 010/0000000. Required: ALUControlE = 001, then 010, then 101 on successive cycles. Also addi with func7[5] = 1 gives 000.
- Branch: beq in E with zeroE = 1 gives PCSrcE = 1; zeroE = 0 gives PCSrcE = 0. jal gives PCSrcE = 1 regardless of zeroE, and ResultSrcW = 10 two cycles later.
- Flush: sw in Decode with FlushE = 1 at the edge. Required: MemWriteM = 0 one cycle later. The preceding instruction in E still reaches M and W unchanged.
- UC_BNE_EN: opcode 1100011, func3 = 001. With zeroE = 0, PCSrcE = 1; with zeroE = 1, PCSrcE = 0. With the macro undefined, the same stimulus gives the beq behaviour.
